// File: rtl/audio_in_level_detector.sv
// Microphone level detector: drains audio-in sample pairs and reports the windowed peak magnitude,
// then fires a one-cycle trigger when that peak exceeds a threshold, followed by a re-arm hold-off.
module audio_in_level_detector #(
   parameter int WINDOW_LOG2     = 12,
   parameter int HOLDOFF_WINDOWS = 4
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   input  logic        enable,
   input  logic        audio_in_available,
   input  logic [31:0] left_channel_audio_in,
   input  logic [31:0] right_channel_audio_in,
   output logic        read_audio_in,
   input  logic [31:0] threshold,
   output logic [31:0] level,
   output logic        level_valid,
   output logic        trigger,
   output logic        armed
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_FIRE    = 2'd2;
   localparam logic [1:0] ST_HOLDOFF = 2'd3;
   localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_WINDOWS);

   logic [1:0]             state;
   logic                   s1_valid;
   logic [31:0]            s1_mag;
   logic [31:0]            left_mag;
   logic [31:0]            right_mag;
   logic [31:0]            max_mag;
   logic [31:0]            peak;
   logic [31:0]            peak_next;
   logic [WINDOW_LOG2-1:0] wcnt;
   logic [7:0]             hcnt;

   // -2^31 has no positive 32-bit counterpart, so it saturates to the largest positive value.
   function automatic logic [31:0] sat_abs(input logic [31:0] s);
      logic [31:0] r;
      if (!s[31])
         r = s;
      else if (s == 32'h8000_0000)
         r = 32'h7FFF_FFFF;
      else
         r = -s;
      return r;
   endfunction

   // Handshake: a pair is popped in every cycle where read_audio_in=1; it is never stalled,
   // so the codec FIFO drains even while the detector is disabled.
   assign read_audio_in = audio_in_available & resetn;

   always_comb begin
      left_mag  = sat_abs(left_channel_audio_in);
      right_mag = sat_abs(right_channel_audio_in);
      max_mag   = (left_mag > right_mag) ? left_mag : right_mag;
      peak_next = (s1_mag > peak) ? s1_mag : peak;
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_mag   <= 32'd0;
      end else begin
         s1_valid <= read_audio_in & enable;
         s1_mag   <= max_mag;
      end
   end

   // The closing sample is folded into the reported level; the next window starts from zero.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         peak        <= 32'd0;
         wcnt        <= '0;
         level       <= 32'd0;
         level_valid <= 1'b0;
      end else if (!enable) begin
         peak        <= 32'd0;
         wcnt        <= '0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (s1_valid) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
               level       <= peak_next;
               peak        <= 32'd0;
               level_valid <= 1'b1;
            end else begin
               peak <= peak_next;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn || !enable) begin
         state <= ST_IDLE;
         hcnt  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE:  state <= ST_ARMED;
            ST_ARMED: begin
               if (level_valid && (level > threshold))
                  state <= ST_FIRE;
            end
            ST_FIRE: begin
               hcnt  <= 8'd0;
               state <= ST_HOLDOFF;
            end
            default: begin
               if (level_valid) begin
                  hcnt <= hcnt + 8'd1;
                  if ((hcnt + 8'd1) == HOLD_LAST)
                     state <= ST_ARMED;
               end
            end
         endcase
      end
   end

   assign trigger = (state == ST_FIRE);
   assign armed   = (state == ST_ARMED);

endmodule

// File: tb/tb_audio_in_level_detector.sv
// Bench for audio_in_level_detector: window-based reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_audio_in_level_detector;

   localparam int WLOG  = 2;
   localparam int HOLD  = 2;
   localparam int WSIZE = 1 << WLOG;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   logic        enable;
   logic        audio_in_available;
   logic [31:0] left_channel_audio_in;
   logic [31:0] right_channel_audio_in;
   logic        read_audio_in;
   logic [31:0] threshold;
   logic [31:0] level;
   logic        level_valid;
   logic        trigger;
   logic        armed;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int lv_cnt = 0;
   int trig_cnt = 0;
   bit started = 1'b0;

   audio_in_level_detector #(.WINDOW_LOG2(WLOG), .HOLDOFF_WINDOWS(HOLD)) dut (
      .CLOCK_50(CLOCK_50),
      .resetn(resetn),
      .enable(enable),
      .audio_in_available(audio_in_available),
      .left_channel_audio_in(left_channel_audio_in),
      .right_channel_audio_in(right_channel_audio_in),
      .read_audio_in(read_audio_in),
      .threshold(threshold),
      .level(level),
      .level_valid(level_valid),
      .trigger(trigger),
      .armed(armed)
   );

   // ---------------- clock ----------------
   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- reference model ----------------
   // Samples of the open window, closed windows awaiting report, and the arm/fire/hold mode.
   typedef enum int {M_OFF, M_ARMED, M_FIRING, M_HOLD} mode_t;
   logic [31:0] win_q[$];
   int          due_e[$];
   logic [31:0] due_v[$];
   mode_t       mode = M_OFF;
   int          hold_left = 0;
   int          edge_no = 0;
   logic [31:0] m_level = 32'd0;
   logic        m_lv = 1'b0;

   function automatic logic [31:0] mag_of(input logic [31:0] s);
      longint v;
      v = longint'($signed(s));
      if (v < 0) v = -v;
      if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
      return v[31:0];
   endfunction

   always @(posedge CLOCK_50) begin
      logic [31:0] mx;
      logic [31:0] a;
      logic [31:0] b;
      edge_no++;
      started <= 1'b1;
      if (!resetn) begin
         win_q.delete(); due_e.delete(); due_v.delete();
         mode = M_OFF; hold_left = 0; m_level = 32'd0; m_lv = 1'b0;
      end else if (!enable) begin
         win_q.delete(); due_e.delete(); due_v.delete();
         mode = M_OFF; hold_left = 0; m_lv = 1'b0;
      end else begin
         case (mode)
            M_OFF:    mode = M_ARMED;
            M_ARMED:  if (m_lv && m_level > threshold) mode = M_FIRING;
            M_FIRING: begin mode = M_HOLD; hold_left = HOLD; end
            default:  if (m_lv) begin
                         hold_left--;
                         if (hold_left == 0) mode = M_ARMED;
                      end
         endcase
         m_lv = 1'b0;
         if (due_e.size() > 0 && due_e[0] == edge_no) begin
            m_lv = 1'b1;
            m_level = due_v[0];
            void'(due_e.pop_front());
            void'(due_v.pop_front());
         end
         if (audio_in_available) begin
            a = mag_of(left_channel_audio_in);
            b = mag_of(right_channel_audio_in);
            win_q.push_back((a > b) ? a : b);
            if (win_q.size() == WSIZE) begin
               mx = 32'd0;
               foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
               due_e.push_back(edge_no + 1);
               due_v.push_back(mx);
               win_q.delete();
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge CLOCK_50) begin
      if (started) begin
         chk("read_audio_in", {31'd0, read_audio_in}, {31'd0, audio_in_available & resetn});
         chk("level", level, m_level);
         chk("level_valid", {31'd0, level_valid}, {31'd0, m_lv});
         chk("trigger", {31'd0, trigger}, {31'd0, mode == M_FIRING});
         chk("armed", {31'd0, armed}, {31'd0, mode == M_ARMED});
         rd_cnt   += int'(read_audio_in === 1'b1);
         lv_cnt   += int'(level_valid === 1'b1);
         trig_cnt += int'(trigger === 1'b1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic send(input logic [31:0] l, input logic [31:0] r);
      audio_in_available     = 1'b1;
      left_channel_audio_in  = l;
      right_channel_audio_in = r;
      tick(1);
      audio_in_available     = 1'b0;
   endtask

   task automatic send_window(input logic [31:0] pk);
      send(pk, 32'd0);
      for (int i = 1; i < WSIZE; i++) send(32'd0, 32'd0);
   endtask

   task automatic wait_level(input string name, input logic [31:0] exp);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge CLOCK_50);
         if (level_valid === 1'b1) seen = 1'b1;
      end
      chk({name, " seen"}, {31'd0, seen}, 32'd1);
      if (seen) chk(name, level, exp);
      tick(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int t0;
      resetn = 1'b0; enable = 1'b0; audio_in_available = 1'b1;
      left_channel_audio_in = 32'd7; right_channel_audio_in = 32'd7;
      threshold = 32'hFFFF_FFFF;
      @(posedge CLOCK_50); #1;
      tick(3);
      // 1: reset holds the pop strobe low; disabled detector still drains
      @(negedge CLOCK_50);
      chk("reset read", {31'd0, read_audio_in}, 32'd0);
      chk("reset level", level, 32'd0);
      #4;
      audio_in_available = 1'b0;
      resetn = 1'b1;
      tick(1);
      rd_cnt = 0; lv_cnt = 0;
      for (int i = 0; i < 8; i++) send(32'd900, 32'hFFFF_FC00);
      tick(3);
      chk("drain pops", rd_cnt, 32'd8);
      chk("drain no level", lv_cnt, 32'd0);

      // 2: peak and latency
      enable = 1'b1;
      send(32'd5, -32'sd9);
      send(32'd100, 32'd3);
      send(-32'sd200, 32'd7);
      send(32'd1, 32'd1);
      @(negedge CLOCK_50);
      chk("latency N+1", {31'd0, level_valid}, 32'd0);
      @(negedge CLOCK_50);
      chk("latency N+2", {31'd0, level_valid}, 32'd1);
      chk("peak 200", level, 32'd200);
      tick(1);
      send_window(32'd0);
      wait_level("zero window", 32'd0);

      // 3: threshold is strict
      threshold = 32'd200;
      t0 = trig_cnt;
      send_window(32'd200);
      wait_level("equal peak", 32'd200);
      tick(2);
      chk("equal no trigger", trig_cnt - t0, 32'd0);
      send_window(-32'sd201);
      wait_level("above peak", 32'd201);
      tick(2);
      chk("above trigger", trig_cnt - t0, 32'd1);

      // 4: hold-off; re-arm via a one-cycle disable first
      enable = 1'b0; tick(1); enable = 1'b1; tick(1);
      threshold = 32'd100;
      t0 = trig_cnt;
      for (int w = 0; w < 4; w++) send_window(32'd500);
      tick(4);
      chk("holdoff triggers", trig_cnt - t0, 32'd2);

      // 5: saturation
      threshold = 32'hFFFF_FFFF;
      enable = 1'b0; tick(1); enable = 1'b1;
      send(32'h8000_0000, 32'd0);
      send(32'd0, 32'h8000_0001);
      send(32'd0, 32'd0);
      send(32'd0, 32'd0);
      wait_level("saturate", 32'h7FFF_FFFF);

      // 6: disable mid-window abandons it
      threshold = 32'd1000;
      send(32'd900, 32'd900);
      send(32'd900, 32'd900);
      enable = 1'b0; tick(1); enable = 1'b1;
      for (int i = 0; i < 4; i++) send(32'd50, -32'sd50);
      wait_level("after disable", 32'd50);
      t0 = trig_cnt;
      threshold = 32'd10;
      send(32'd900, 32'd900);
      send(32'd900, 32'd900);
      resetn = 1'b0; tick(1); resetn = 1'b1;
      @(negedge CLOCK_50);
      chk("reset level mid", level, 32'd0);
      tick(1);
      threshold = 32'd1000;
      for (int i = 0; i < 4; i++) send(32'd50, 32'd0);
      wait_level("after reset", 32'd50);
      tick(3);
      chk("reset no trigger", trig_cnt - t0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "timeout");
   end

endmodule
